// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter with valid/ready handshake and ZNCV flags
module shifter_pipe #(
  parameter int                       WIDTH      = 32,
  parameter logic [$clog2(WIDTH)-1:0] REG_STAGES = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     dir,
  input  logic [2:0]               func,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [3:0]               flag_out
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] F_LOG = 3'b100;
  localparam logic [2:0] F_ARI = 3'b010;
  localparam logic [2:0] F_ROT = 3'b001;

  // Everything an operation needs on its way through the network.
  // msb is the operand's original sign bit: it drives arithmetic fill and
  // the overflow check at every stage, whatever the partial result holds.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             msb;
    logic             dir;
    logic [2:0]       func;
    logic [SHW-1:0]   shamt;
    logic             c;
    logic             v;
  } op_t;

  op_t  st   [SHW+1];
  logic st_v [SHW+1];

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] data_q;
  logic [3:0]       flag_q;

  // The whole pipeline moves as one: it stalls only when the output is
  // occupied and not being taken.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign st[0] = '{data: data_in, msb: data_in[WIDTH-1], dir: dir, func: func,
                   shamt: shamt, c: 1'b0, v: 1'b0};
  assign st_v[0] = in_valid;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int K = 2 ** (SHW - 1 - i);
    // Top K+1 bits: the bits leaving on a left shift plus the new MSB.
    localparam logic [WIDTH-1:0] VMASK = ~({WIDTH{1'b1}} >> (K + 1));

    op_t              cur;
    op_t              stage_d;
    logic             act;
    logic [WIDTH-1:0] fill;

    assign cur  = st[i];
    assign act  = cur.shamt[SHW-1-i] &&
                  (cur.func == F_LOG || cur.func == F_ARI || cur.func == F_ROT);
    assign fill = (cur.func == F_ARI && cur.dir) ? {WIDTH{cur.msb}} : '0;

    // Conditional shift by K; C tracks the last bit pushed past the boundary,
    // V accumulates as a sticky bit for arithmetic left shifts.
    always_comb begin
      stage_d = cur;
      if (act) begin
        if (cur.func == F_ROT) begin
          if (cur.dir) stage_d.data = (cur.data >> K) | (cur.data << (WIDTH - K));
          else         stage_d.data = (cur.data << K) | (cur.data >> (WIDTH - K));
        end else if (cur.dir) begin
          stage_d.data = (cur.data >> K) | (fill << (WIDTH - K));
        end else begin
          stage_d.data = cur.data << K;
        end
        stage_d.c = cur.dir ? cur.data[K-1] : cur.data[WIDTH-K];
        if (cur.func == F_ARI && !cur.dir) begin
          stage_d.v = cur.v | (|((cur.data ^ {WIDTH{cur.msb}}) & VMASK));
        end
      end
    end

    if (REG_STAGES[i]) begin : g_reg
      op_t  stage_q;
      logic stage_v_q;

      // Optional pipeline register after this stage; holds on backpressure.
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_q   <= '0;
          stage_v_q <= 1'b0;
        end else if (advance) begin
          stage_q   <= stage_d;
          stage_v_q <= st_v[i];
        end
      end

      assign st[i+1]   = stage_q;
      assign st_v[i+1] = stage_v_q;
    end else begin : g_wire
      assign st[i+1]   = stage_d;
      assign st_v[i+1] = st_v[i];
    end
  end

  op_t  fin;
  logic unused_fin;

  assign fin = st[SHW];
  // Control fields have no use once the last stage has been applied.
  assign unused_fin = ^{fin.msb, fin.dir, fin.func, fin.shamt};

  // Output register: result and flags are captured only for a valid operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      flag_q      <= '0;
    end else if (advance) begin
      out_valid_q <= st_v[SHW];
      if (st_v[SHW]) begin
        data_q <= fin.data;
        flag_q <= {(fin.data == '0), fin.data[WIDTH-1], fin.c, fin.v};
      end
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign flag_out  = flag_q;

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational barrel shifter in the execute datapath.
- Width is generic. The shift network is log2(WIDTH) binary stages, and a mask parameter selects which stages get pipeline registers.
- Adds a valid/ready handshake with full-pipeline backpressure and a real overflow (V) flag.
- Fixes the sign-source bugs of the earlier shifter: N, and the arithmetic fill at every stage, use the true MSB.

Parameters:
- WIDTH, 32, data width; power of two, at least 4.
- SHW, log2(WIDTH), shift-amount width; derived, not overridable.
- REG_STAGES, 0, SHW-bit mask; bit i set places a register after stage i (stage i shifts by 2^(SHW-1-i)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an input this cycle
- data_in  in  WIDTH  operand
- dir  in  1  shift direction: 1 = right, 0 = left
- func  in  3  operation: 3'b100 logical, 3'b010 arithmetic, 3'b001 rotate, other = pass-through
- shamt  in  SHW  shift amount, 0..WIDTH-1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- data_out  out  WIDTH  shifted result
- flag_out  out  4  {Z, N, C, V}

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: out_valid=0, data_out=0, flag_out=0, every internal stage valid=0. A reset mid-operation discards all in-flight operations with no output.
- Latency: 1 + popcount(REG_STAGES) cycles from input acceptance to out_valid. The output register always exists. With REG_STAGES=0 the network is combinational into the output register.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance, which is combinational from out_ready.
  - An input is accepted when in_valid & in_ready.
  - When advance=0 the whole pipeline holds: every register keeps its data, flags and valid.
  - Bubbles are not compressed.
  - Result transfer happens when out_valid & out_ready.
  - The sequence order of operations is preserved.
- Control fields: dir, func and the remaining shamt bits travel with the data through each register.
- Logical: zero fill at the vacated end.
- Arithmetic:
  - Right: fill with the operand's original MSB at every stage.
  - Left: identical to logical left.
- Rotate: the bits that leave one end enter the other end.
- Pass-through (func not one-hot as above): data unchanged, C=0, V=0.
- shamt=0: data unchanged, C=0, V=0, for every func.
- Z = (data_out == 0).
- N = data_out[WIDTH-1].
- C = value of the last bit moved past the data boundary:
  - Right shift by n: data_in[n-1].
  - Left shift by n: data_in[WIDTH-n].
  - Rotate: the same bit, which equals data_out[WIDTH-1] for right and data_out[0] for left.
  - 0 when shamt=0.
- V: 1 only for an arithmetic left shift where any bit shifted out, or the final MSB, differs from the original MSB. Otherwise V=0.
- V must be computed across stages with a sticky bit carried in the pipeline, not recomputed at the output.
- No illegal shamt exists: WIDTH-1 is the maximum.
- Simultaneous accept and output transfer in the same cycle is legal and sustains throughput of one per cycle.

Test Plan:
- WIDTH=32, REG_STAGES=0: arithmetic right, data_in=0x80000000, shamt=4 -> after 1 cycle data_out=0xF8000000, flags Z=0 N=1 C=0 V=0.
- Logical left, 0x80000001, shamt=1 -> data_out=0x00000002, C=1, V=0. Arithmetic left, 0x40000000, shamt=1 -> data_out=0x80000000, N=1, V=1.
- Rotate right, 0x00000001, shamt=1 -> data_out=0x80000000, C=1. Rotate left by 0, 0x12345678 -> data_out=0x12345678, C=0. Logical right, 0x0000000F, shamt=4 -> data_out=0, Z=1, C=1.
- Func=3'b111 with shamt=5 on 0xA5A5A5A5 -> data_out=0xA5A5A5A5, all flags 0 except N=1.
- REG_STAGES=5'b10101 (latency 4):
  - Stream 6 back-to-back operations.
  - Hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 during the hold, no operation lost or duplicated, results in order with the same values as the REG_STAGES=0 model.
- Assert reset for 1 cycle with 3 operations in flight -> out_valid=0 and data_out=0 the next cycle; no stale result appears afterwards. Repeat all checks at WIDTH=8, e.g. arithmetic right 0x90 by 3 -> 0xF2, C=0.
